// File: rtl/sig_ctrl.sv
// Purpose: key conditioning, rate index and burst/gap sequencing for a PRBS-9 generator.
// Latency: key to press pulse is 2 sync cycles (+ DEB_CYCLES with SIG_CTRL_DEB_EN); all outputs registered.
// Backpressure: none; bit_tick paces the FSM, the press pulse is acted on the cycle it appears.
module sig_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int BURST_BITS = 511,
    parameter int GAP_BITS   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_run,
    input  logic       bit_tick,
    output logic [3:0] rate_sel,
    output logic       gen_en,
    output logic       frame_sync,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_BURST = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] BURST_LAST = 16'(BURST_BITS);
    // ARM always spends one idle bit period, so GAP itself covers GAP_BITS-1 ticks
    localparam logic [15:0] GAP_LAST   = 16'(GAP_BITS - 1);

    // bit order: [0]=up, [1]=down, [2]=run
    logic [2:0] key_raw;
    logic [2:0] sync1, sync2;
    logic [2:0] cond, cond_q;
    logic [2:0] armed;
    logic [1:0] fill;
    logic [2:0] press;

    assign key_raw = {key_run, key_down, key_up};

    // two-flop synchronizer; armed only once a valid low level has been seen, so a key
    // held through reset release cannot produce a press
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            fill   <= '0;
            armed  <= '0;
            cond_q <= '0;
        end else begin
            sync1  <= key_raw;
            sync2  <= sync1;
            fill   <= {fill[0], 1'b1};
            armed  <= armed | ({3{fill[1]}} & ~sync2);
            cond_q <= cond;
        end
    end

`ifdef SIG_CTRL_DEB_EN
    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    deb_lvl;

    // accept a new level after DEB_CYCLES consecutive samples differing from the current one
    always_ff @(posedge clk) begin
        if (rst_n) begin
            deb_lvl <= '0;
            for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == deb_lvl[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb_lvl[k] <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DW'(1);
                end
            end
        end
    end

    assign cond = deb_lvl;
`else
    // debounce depth has no meaning without the debounce counters
    logic deb_unused;
    assign deb_unused = (DEB_CYCLES > 0);
    assign cond = sync2;
`endif

    assign press = cond & ~cond_q & armed;

    state_t      st, st_nxt;
    logic [15:0] bit_cnt, cnt_nxt;
    logic        stop_pend, stop_nxt;
    logic [3:0]  rate_pend, pend_nxt, rate_nxt;
    logic        gen_nxt, fs_nxt;

    // next-state, counter, rate and registered-output values
    always_comb begin
        st_nxt   = st;
        cnt_nxt  = bit_cnt;
        stop_nxt = stop_pend;
        pend_nxt = rate_pend;
        rate_nxt = rate_sel;
        fs_nxt   = 1'b0;

        if (press[0] && !press[1]) begin
            pend_nxt = (rate_pend == 4'd9) ? 4'd0 : rate_pend + 4'd1;
        end else if (press[1] && !press[0]) begin
            pend_nxt = (rate_pend == 4'd0) ? 4'd9 : rate_pend - 4'd1;
        end

        case (st)
            S_IDLE: begin
                if (press[2]) st_nxt = S_ARM;
            end
            S_ARM: begin
                if (press[2]) begin
                    st_nxt = S_IDLE;
                end else if (bit_tick) begin
                    st_nxt  = S_BURST;
                    fs_nxt  = 1'b1;
                    cnt_nxt = 16'd1;
                end
            end
            S_BURST: begin
                if (press[2]) stop_nxt = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt == BURST_LAST) begin
                        cnt_nxt = 16'd0;
                        if (stop_nxt)           st_nxt = S_IDLE;
                        else if (GAP_BITS == 1) st_nxt = S_ARM;
                        else                    st_nxt = S_GAP;
                    end else begin
                        cnt_nxt = bit_cnt + 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (press[2]) begin
                    st_nxt = S_IDLE;
                end else if (bit_tick) begin
                    if (bit_cnt + 16'd1 == GAP_LAST) begin
                        cnt_nxt = 16'd0;
                        st_nxt  = stop_pend ? S_IDLE : S_ARM;
                    end else begin
                        cnt_nxt = bit_cnt + 16'd1;
                    end
                end
            end
            default: st_nxt = S_IDLE;
        endcase

        if (st_nxt == S_IDLE) stop_nxt = 1'b0;
        // rate_sel only moves in IDLE or on entry to ARM, never inside a burst
        if (st_nxt == S_IDLE || (st_nxt == S_ARM && st != S_ARM)) rate_nxt = pend_nxt;
        gen_nxt = (st_nxt == S_BURST);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            st         <= S_IDLE;
            bit_cnt    <= '0;
            stop_pend  <= 1'b0;
            rate_pend  <= '0;
            rate_sel   <= '0;
            gen_en     <= 1'b0;
            frame_sync <= 1'b0;
        end else begin
            st         <= st_nxt;
            bit_cnt    <= cnt_nxt;
            stop_pend  <= stop_nxt;
            rate_pend  <= pend_nxt;
            rate_sel   <= rate_nxt;
            gen_en     <= gen_nxt;
            frame_sync <= fs_nxt;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_sig_ctrl.sv
// Bench for sig_ctrl: key conditioning, rate wrap, burst/gap timing, stop and reset behaviour.
// Reference model works on whole presses and tick counts rather than cycles.
// Drives and checks on the falling edge of clk.
module tb_sig_ctrl;
    localparam int DEB = 4;
    localparam int BB  = 5;
    localparam int GB  = 2;
    localparam int TP  = 8;
`ifdef SIG_CTRL_DEB_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_up = 1'b0, key_down = 1'b0, key_run = 1'b0;
    logic       bit_tick = 1'b0;
    logic [3:0] rate_sel;
    logic       gen_en, frame_sync;
    logic [1:0] state;

    int n_asserts = 0;
    int n_fail = 0;
    int m_rate = 0;
    logic tick_en = 1'b0;
    int tick_ph = 0;

    always #5 clk = ~clk;

    sig_ctrl #(.DEB_CYCLES(DEB), .BURST_BITS(BB), .GAP_BITS(GB)) dut (
        .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down), .key_run(key_run),
        .bit_tick(bit_tick), .rate_sel(rate_sel), .gen_en(gen_en), .frame_sync(frame_sync),
        .state(state)
    );

    // bit_tick generator: one pulse every TP cycles while enabled
    always @(negedge clk) begin
        if (tick_en) begin
            tick_ph  = (tick_ph + 1) % TP;
            bit_tick = (tick_ph == 0);
        end else begin
            tick_ph  = 0;
            bit_tick = 1'b0;
        end
    end

    // monitor: tick numbering, frame positions, ticks spent with gen_en high per burst
    int   tick_no = 0, cur_len = 0, fs_double = 0, gap_cnt = 0;
    logic gen_prev = 1'b0, fs_prev = 1'b0;
    int   frame_q[$];
    int   len_q[$];
    always @(posedge clk) begin
        #1;
        if (bit_tick) begin
            tick_no++;
            if (gen_prev) cur_len++;
        end
        if (frame_sync) frame_q.push_back(tick_no);
        if (frame_sync && fs_prev) fs_double++;
        if (gen_prev && !gen_en) begin
            len_q.push_back(cur_len);
            cur_len = 0;
        end
        if (state == 2'd3) gap_cnt++;
        gen_prev = gen_en;
        fs_prev  = frame_sync;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit accepted(input int len);
`ifdef SIG_CTRL_DEB_EN
        return (len >= DEB);
`else
        return (len >= 1);
`endif
    endfunction

    // model of one press of the keys in mask ([0]=up, [1]=down, [2]=run)
    task automatic model_press(input logic [2:0] mask, input int len);
        if (accepted(len)) begin
            if (mask[0] && !mask[1]) m_rate = (m_rate + 1) % 10;
            else if (mask[1] && !mask[0]) m_rate = (m_rate + 9) % 10;
        end
    endtask

    task automatic press(input logic [2:0] mask, input int len);
        {key_run, key_down, key_up} = mask;
        cyc(len);
        {key_run, key_down, key_up} = 3'b000;
        cyc(len + DEB + 8);
    endtask

    initial begin
        int f0, l0, g0, n0, r;
        logic [2:0] mask;
        int len;

        // reset state
        cyc(3);
        chk("rst_state", state, 0);
        chk("rst_gen_en", gen_en, 0);
        chk("rst_frame_sync", frame_sync, 0);
        chk("rst_rate", rate_sel, 0);
        rst_n = 1'b0;
        cyc(4);

        // short glitches then a long press on key_up
        for (int g = 1; g <= 3; g++) begin
            press(3'b001, g);
            model_press(3'b001, g);
            chk("glitch_rate", rate_sel, m_rate);
        end
        press(3'b001, 10);
        model_press(3'b001, 10);
        chk("long_press_rate", rate_sel, m_rate);

        // down sweep from reset, wrap both ways
        rst_n = 1'b1; cyc(2); rst_n = 1'b0; cyc(4);
        m_rate = 0;
        for (int i = 0; i < 9; i++) begin
            press(3'b010, 10);
            model_press(3'b010, 10);
            chk("down_seq", rate_sel, m_rate);
        end
        press(3'b010, 10); model_press(3'b010, 10);
        press(3'b010, 10); model_press(3'b010, 10);
        chk("wrap_down_to_9", rate_sel, m_rate);
        press(3'b001, 10); model_press(3'b001, 10);
        chk("wrap_up_to_0", rate_sel, m_rate);

        // idle rate change appears one cycle after the press pulse
        key_up = 1'b1;
        cyc(LAT - 1);
        chk("idle_lat_before", rate_sel, m_rate);
        cyc(1);
        model_press(3'b001, 10);
        chk("idle_lat_after", rate_sel, m_rate);
        cyc(10 - LAT);
        key_up = 1'b0;
        cyc(DEB + 20);

        // random up/down/both presses of random length
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(2, 0);
            mask = (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : 3'b011;
            len = $urandom_range(12, 1);
            press(mask, len);
            model_press(mask, len);
            chk("rand_rate", rate_sel, m_rate);
        end

        // free-running bursts
        tick_en = 1'b1;
        cyc(3);
        f0 = frame_q.size();
        l0 = len_q.size();
        press(3'b100, 10);
        for (int i = 0; i < 2000 && frame_q.size() < f0 + 4; i++) cyc(1);
        chk("frames_seen", frame_q.size() >= f0 + 4, 1);
        for (int i = 1; i < 4; i++)
            chk("frame_period", frame_q[f0 + i] - frame_q[f0 + i - 1], BB + GB);
        for (int i = 0; i < 3; i++)
            chk("burst_len", len_q[l0 + i], BB);
        chk("fs_one_cycle", fs_double, 0);
        chk("run_rate_stable", rate_sel, m_rate);

        // stop requested mid-burst together with an up press
        for (int i = 0; i < 400 && !frame_sync; i++) cyc(1);
        chk("wait_frame", frame_sync, 1);
        for (int i = 0; i < 400 && cur_len < 2; i++) cyc(1);
        chk("wait_tick2", cur_len, 2);
        g0 = gap_cnt;
        l0 = len_q.size();
        {key_run, key_up} = 2'b11;
        cyc(6);
        {key_run, key_up} = 2'b00;
        cyc(2);
        chk("stop_still_burst", state, 2);
        chk("stop_rate_held", rate_sel, m_rate);
        model_press(3'b101, 6);
        for (int i = 0; i < 400 && state != 2'd0; i++) cyc(1);
        chk("stop_idle", state, 0);
        chk("stop_one_burst", len_q.size() - l0, 1);
        chk("stop_burst_len", len_q[l0], BB);
        chk("stop_rate_on_idle", rate_sel, m_rate);
        chk("stop_no_gap", gap_cnt - g0, 0);
        n0 = frame_q.size();
        cyc(100);
        chk("stop_no_frames", frame_q.size() - n0, 0);

        // reset asserted mid-burst, run key held through release
        press(3'b100, 10);
        for (int i = 0; i < 400 && !frame_sync; i++) cyc(1);
        chk("wait_frame2", frame_sync, 1);
        for (int i = 0; i < 400 && cur_len < 1; i++) cyc(1);
        chk("wait_rst_tick", cur_len, 1);
        rst_n = 1'b1;
        key_run = 1'b1;
        cyc(1);
        m_rate = 0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_gen_en", gen_en, 0);
        chk("mid_rst_rate", rate_sel, m_rate);
        cyc(2);
        n0 = frame_q.size();
        rst_n = 1'b0;
        cyc(30);
        chk("held_key_idle", state, 0);
        key_run = 1'b0;
        cyc(30);
        chk("held_key_idle2", state, 0);
        chk("held_key_no_frames", frame_q.size() - n0, 0);
        chk("held_key_gen_en", gen_en, 0);
        tick_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/sig_ctrl.md
SIG_CTRL -- requirements
Module: sig_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000: clock cycles a synchronized key level must hold before acceptance.
REQ-002 Parameter BURST_BITS, default 511: bit periods per burst (one PRBS-9 period); legal range 1..65535.
REQ-003 Parameter GAP_BITS, default 16: idle bit periods between bursts; legal range 1..65535.
REQ-004 clk  input  1  system clock; the single clock domain of the block.
REQ-005 rst_n  input  1  reset; synchronous and active-high despite the name; sampled on the rising edge of clk.
REQ-006 key_up  input  1  raw button, active-high, asynchronous: step the rate index up.
REQ-007 key_down  input  1  raw button, active-high, asynchronous: step the rate index down.
REQ-008 key_run  input  1  raw button, active-high, asynchronous: toggle run/stop.
REQ-009 bit_tick  input  1  one-cycle pulse from the generator marking each bit boundary.
REQ-010 rate_sel  output  4  rate index to the generator, 0..9 (10 kbit/s .. 100 kbit/s).
REQ-011 gen_en  output  1  high while burst bits are to be transmitted.
REQ-012 frame_sync  output  1  one-cycle pulse marking the first bit of each burst.
REQ-013 state  output  2  current FSM state: IDLE=0, ARM=1, BURST=2, GAP=3.

Function
REQ-014 Each key SHALL pass a 2-flop synchronizer, then the REQ-039 conditioner, producing a one-cycle press pulse on each accepted 0->1 transition.
REQ-015 FSM IDLE: gen_en=0; a run press SHALL move to ARM.
REQ-016 FSM ARM: gen_en=0; the next bit_tick SHALL move to BURST, pulse frame_sync in that same cycle, and load the bit counter with 1.
REQ-017 FSM BURST: gen_en=1; each bit_tick increments the bit counter; the bit_tick at which the count equals BURST_BITS SHALL exit BURST.
REQ-018 BURST exit: if a stop is pending, go to IDLE and clear it; otherwise go to GAP with the counter reset to 0.
REQ-019 FSM GAP: gen_en=0; the bit_tick at which GAP_BITS ticks have been counted SHALL move to ARM, or to IDLE if a stop is pending.
REQ-020 A run press in ARM or GAP SHALL go to IDLE on the next cycle; in BURST it SHALL set stop-pending, so a burst is never truncated.
REQ-021 An up press SHALL increment the rate index, 9 wrapping to 0; a down press SHALL decrement it, 0 wrapping to 9.
REQ-022 Up and down presses in the same cycle SHALL both be discarded.
REQ-023 In IDLE a rate change SHALL reach rate_sel on the cycle after the press.
REQ-024 In ARM, BURST or GAP a rate change SHALL be held pending (latest value wins) and copied to rate_sel on the transition into ARM or IDLE; rate_sel never changes inside a burst.
REQ-025 bit_tick coincident with a run press SHALL be processed in the same cycle, with the run press taking priority.
REQ-026 The bit counter SHALL be 16 bits and SHALL never wrap within a state.
REQ-027 All outputs SHALL be registered; frame_sync SHALL be high for exactly one cycle per burst.

Reset
REQ-028 While rst_n=1 at a clock edge: state=IDLE, gen_en=0, frame_sync=0, rate_sel=0, pending rate=0, stop-pending=0, bit counter=0.
REQ-029 Reset SHALL clear synchronizers, debounce counters and edge-detect history.
REQ-030 Reset asserted mid-burst SHALL drop gen_en on the following edge, with no frame completion.
REQ-031 A key held high through reset release SHALL NOT produce a press pulse.

Configuration
REQ-032 Macro SIG_CTRL_DEB_EN defined: each synchronized key SHALL pass through a debounce counter; a level is accepted only after DEB_CYCLES consecutive equal samples, and any change restarts the counter.
REQ-033 Macro SIG_CTRL_DEB_EN undefined: no debounce logic is built; the press pulse is the rising edge of the synchronized key, and DEB_CYCLES is ignored.
REQ-039 Key conditioner, with SIG_CTRL_DEB_EN defined: the debounce counter of REQ-032; undefined: the synchronizer output is used directly, per REQ-033.

Verification
REQ-034 DEB_CYCLES=4, glitches on key_up of 1-3 cycles -> no rate change; a 10-cycle press -> rate_sel 0->1 exactly once.
REQ-035 Nine down presses from reset -> rate_sel sequence 9,8,...,1; one up press at 9 -> rate_sel=0.
REQ-036 BURST_BITS=5, GAP_BITS=2, bit_tick every 8 cycles, run press -> frame_sync every 7 ticks; gen_en high for exactly 5 ticks per burst.
REQ-037 Run press at burst tick 3 of 5 -> gen_en held through tick 5, then IDLE with no GAP; an up press in the same burst -> rate_sel updates only on entry to IDLE.
REQ-038 Reset asserted at burst tick 2 -> next edge: state=0, gen_en=0, rate_sel=0; key_run held through reset release -> remains IDLE.
